// File: rtl/cleared_memory_block_if.sv
// Request/response bundle between a memory client (master) and cleared_memory_block (slave).
interface cleared_memory_block_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                    ready;
    logic                    read_enable;
    logic [ADDR_WIDTH-1:0]   read_address;
    logic                    read_valid;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    range_error;
    logic                    write_enable;
    logic [ADDR_WIDTH-1:0]   write_address;
    logic [DATA_WIDTH/8-1:0] write_bytes;
    logic [DATA_WIDTH-1:0]   data_in;

    modport master (
        input  ready, read_valid, data_out, range_error,
        output read_enable, read_address, write_enable, write_address, write_bytes, data_in
    );

    modport slave (
        input  read_enable, read_address, write_enable, write_address, write_bytes, data_in,
        output ready, read_valid, data_out, range_error
    );
endinterface

// File: rtl/cleared_memory_block.sv
// Byte-enable 1R1W RAM that fills itself with CLEAR_VALUE after every reset.
// Latency: read data and read_valid one cycle after the request; writes land on the request edge.
// Backpressure: none once ready=1; requests while ready=0 are dropped silently.
module cleared_memory_block #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    DEPTH       = 1 << ADDR_WIDTH,
    parameter bit                    BYPASS      = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    cleared_memory_block_if.slave   io_mem
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_L  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_clear_count;
    logic                    r_ready;
    logic                    r_read_valid;
    logic                    r_range_error;
    logic [DATA_WIDTH-1:0]   r_data_out;
    logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];

    logic                    w_rd_acc;
    logic                    w_wr_acc;
    logic                    w_rd_oor;
    logic                    w_wr_oor;
    logic                    w_fwd;
    logic [MEM_AW-1:0]       w_rd_idx;
    logic [MEM_AW-1:0]       w_wr_idx;
    logic [MEM_AW-1:0]       w_clr_idx;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    assign w_rd_acc  = io_mem.read_enable  && (r_state == ST_READY);
    assign w_wr_acc  = io_mem.write_enable && (r_state == ST_READY);
    assign w_rd_oor  = {1'b0, io_mem.read_address}  >= DEPTH_L;
    assign w_wr_oor  = {1'b0, io_mem.write_address} >= DEPTH_L;
    assign w_rd_idx  = io_mem.read_address[MEM_AW-1:0];
    assign w_wr_idx  = io_mem.write_address[MEM_AW-1:0];
    assign w_clr_idx = r_clear_count[MEM_AW-1:0];
    assign w_fwd     = BYPASS && w_wr_acc && !w_wr_oor
                       && (io_mem.write_address == io_mem.read_address);

    // Forwarded word: enabled bytes from the incoming write, the rest from the array.
    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
        for (int i = 0; i < NBYTES; i++) begin
            if (w_fwd && io_mem.write_bytes[i]) begin
                w_rd_word[8*i +: 8] = io_mem.data_in[8*i +: 8];
            end
        end
    end

    // Storage has no reset so it maps onto a RAM macro; reset only blocks writes.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            if (r_state == ST_CLEAR) begin
                r_mem[w_clr_idx] <= CLEAR_VALUE;
            end else if (w_wr_acc && !w_wr_oor) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (io_mem.write_bytes[i]) begin
                        r_mem[w_wr_idx][8*i +: 8] <= io_mem.data_in[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= ST_CLEAR;
            r_clear_count <= '0;
            r_ready       <= 1'b0;
            r_read_valid  <= 1'b0;
            r_range_error <= 1'b0;
            r_data_out    <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clear_count <= r_clear_count + 1'b1;
                    r_read_valid  <= 1'b0;
                    r_range_error <= 1'b0;
                    if (r_clear_count == LAST_L) begin
                        r_state <= ST_READY;
                        r_ready <= 1'b1;
                    end
                end
                ST_READY: begin
                    r_read_valid  <= w_rd_acc;
                    r_range_error <= (w_rd_acc && w_rd_oor) || (w_wr_acc && w_wr_oor);
                    if (w_rd_acc) begin
                        r_data_out <= w_rd_oor ? CLEAR_VALUE : w_rd_word;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                end
            endcase
        end
    end

    assign io_mem.ready       = r_ready;
    assign io_mem.read_valid  = r_read_valid;
    assign io_mem.range_error = r_range_error;
    assign io_mem.data_out    = r_data_out;
endmodule

// File: tb/tb_cleared_memory_block.sv
// Drives two instances (DEPTH=16/BYPASS=1/CLEAR=A5A5 and DEPTH=20/BYPASS=0/CLEAR=0) with shared stimulus.
module tb_cleared_memory_block;
    logic        clk;
    logic        rst;
    logic        re;
    logic [4:0]  ra;
    logic        we;
    logic [4:0]  wa;
    logic [1:0]  wb;
    logic [15:0] din;

    int n_cmp = 0;
    int n_bad = 0;

    cleared_memory_block_if #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) bus_a ();
    cleared_memory_block_if #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) bus_b ();

    assign bus_a.read_enable   = re;
    assign bus_a.read_address  = ra;
    assign bus_a.write_enable  = we;
    assign bus_a.write_address = wa;
    assign bus_a.write_bytes   = wb;
    assign bus_a.data_in       = din;
    assign bus_b.read_enable   = re;
    assign bus_b.read_address  = ra;
    assign bus_b.write_enable  = we;
    assign bus_b.write_address = wa;
    assign bus_b.write_bytes   = wb;
    assign bus_b.data_in       = din;

    cleared_memory_block #(
        .ADDR_WIDTH(5), .DATA_WIDTH(16), .DEPTH(16), .BYPASS(1'b1), .CLEAR_VALUE(16'hA5A5)
    ) dut_a (
        .i_clock(clk), .i_reset(rst), .io_mem(bus_a)
    );

    cleared_memory_block #(
        .ADDR_WIDTH(5), .DATA_WIDTH(16), .DEPTH(20), .BYPASS(1'b0), .CLEAR_VALUE(16'h0000)
    ) dut_b (
        .i_clock(clk), .i_reset(rst), .io_mem(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, one slot per instance.
    int          m_depth [2] = '{16, 20};
    bit          m_byp   [2] = '{1'b1, 1'b0};
    logic [15:0] m_cv    [2] = '{16'hA5A5, 16'h0000};
    logic [15:0] mmem    [2][32];
    bit          m_ready [2];
    int          m_cnt   [2];
    bit          m_rv    [2];
    bit          m_err   [2];
    logic [15:0] m_dout  [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_ready[k] = 1'b0;
                m_cnt[k]   = 0;
                m_rv[k]    = 1'b0;
                m_err[k]   = 1'b0;
                m_dout[k]  = 16'h0000;
            end else if (!m_ready[k]) begin
                mmem[k][m_cnt[k]] = m_cv[k];
                if (m_cnt[k] == m_depth[k] - 1) m_ready[k] = 1'b1;
                m_cnt[k]++;
                m_rv[k]  = 1'b0;
                m_err[k] = 1'b0;
            end else begin
                logic [15:0] word;
                word = mmem[k][ra];
                if (m_byp[k] && we && (wa == ra)) begin
                    for (int i = 0; i < 2; i++)
                        if (wb[i]) word[8*i +: 8] = din[8*i +: 8];
                end
                if (re) m_dout[k] = (int'(ra) >= m_depth[k]) ? m_cv[k] : word;
                m_rv[k]  = re;
                m_err[k] = (re && int'(ra) >= m_depth[k]) || (we && int'(wa) >= m_depth[k]);
                if (we && int'(wa) < m_depth[k]) begin
                    for (int i = 0; i < 2; i++)
                        if (wb[i]) mmem[k][wa][8*i +: 8] = din[8*i +: 8];
                end
            end
        end
    endtask

    // One clock edge, then every output of both instances is compared with the model.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("A.ready", bus_a.ready,       m_ready[0]);
        chk("A.rv",    bus_a.read_valid,  m_rv[0]);
        chk("A.err",   bus_a.range_error, m_err[0]);
        chk("A.dout",  bus_a.data_out,    m_dout[0]);
        chk("B.ready", bus_b.ready,       m_ready[1]);
        chk("B.rv",    bus_b.read_valid,  m_rv[1]);
        chk("B.err",   bus_b.range_error, m_err[1]);
        chk("B.dout",  bus_b.data_out,    m_dout[1]);
    endtask

    task automatic idle();
        re = 1'b0; ra = '0; we = 1'b0; wa = '0; wb = '0; din = '0;
    endtask

    task automatic wait_ready(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            cycle();
            ok = bus_a.ready && bus_b.ready;
        end
        chk(name, ok, 1'b1);
    endtask

    typedef struct {
        logic        re;
        logic [4:0]  ra;
        logic        we;
        logic [4:0]  wa;
        logic [1:0]  wb;
        logic [15:0] din;
        logic        vld;
        logic [15:0] da;
        logic [15:0] db;
        logic        ea;
        logic        eb;
    } vec_t;

    vec_t vt [16];

    initial begin
        int ca, cb;

        //           re  ra  we  wa  wb     din       vld  doutA     doutB     errA errB
        vt[0]  = '{1'b0, 0, 1'b1, 3, 2'b11, 16'h1234, 1'b0, 16'hA5A5, 16'h0000, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 0, 1'b1, 3, 2'b01, 16'hFFEE, 1'b0, 16'hA5A5, 16'h0000, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 3, 1'b0, 0, 2'b00, 16'h0000, 1'b1, 16'h12EE, 16'h12EE, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 0, 1'b1, 5, 2'b11, 16'h0000, 1'b0, 16'h12EE, 16'h12EE, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 5, 1'b1, 5, 2'b10, 16'hBEEF, 1'b1, 16'hBE00, 16'h0000, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 5, 1'b0, 0, 2'b00, 16'h0000, 1'b1, 16'hBE00, 16'hBE00, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 0, 1'b1, 25, 2'b11, 16'h7777, 1'b0, 16'hBE00, 16'hBE00, 1'b1, 1'b1};
        vt[7]  = '{1'b1, 25, 1'b0, 0, 2'b00, 16'h0000, 1'b1, 16'hA5A5, 16'h0000, 1'b1, 1'b1};
        vt[8]  = '{1'b1, 18, 1'b0, 0, 2'b00, 16'h0000, 1'b1, 16'hA5A5, 16'h0000, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 9, 1'b0, 0, 2'b00, 16'h0000, 1'b1, 16'hA5A5, 16'h0000, 1'b0, 1'b0};
        vt[10] = '{1'b0, 0, 1'b0, 0, 2'b00, 16'h0000, 1'b0, 16'hA5A5, 16'h0000, 1'b0, 1'b0};
        vt[11] = '{1'b1, 3, 1'b1, 3, 2'b00, 16'h5555, 1'b1, 16'h12EE, 16'h12EE, 1'b0, 1'b0};
        vt[12] = '{1'b1, 5, 1'b1, 6, 2'b11, 16'h6666, 1'b1, 16'hBE00, 16'hBE00, 1'b0, 1'b0};
        vt[13] = '{1'b1, 6, 1'b0, 0, 2'b00, 16'h0000, 1'b1, 16'h6666, 16'h6666, 1'b0, 1'b0};
        vt[14] = '{1'b1, 6, 1'b1, 30, 2'b11, 16'h0001, 1'b1, 16'h6666, 16'h6666, 1'b1, 1'b1};
        vt[15] = '{1'b0, 0, 1'b0, 0, 2'b00, 16'h0000, 1'b0, 16'h6666, 16'h6666, 1'b0, 1'b0};

        idle();
        rst = 1'b1;
        cycle();
        cycle();
        chk("reset A.ready", bus_a.ready, 1'b0);
        chk("reset A.dout",  bus_a.data_out, 16'h0000);

        // Partial clear with dropped requests, then reset at clear cycle 9.
        rst = 1'b0;
        re = 1'b1; ra = 5'd2; we = 1'b1; wa = 5'd2; wb = 2'b11; din = 16'hDEAD;
        for (int n = 0; n < 8; n++) cycle();
        rst = 1'b1;
        cycle();
        chk("midclear A.ready", bus_a.ready, 1'b0);
        rst = 1'b0;

        ca = 0; cb = 0;
        for (int n = 1; n <= 40 && (ca == 0 || cb == 0); n++) begin
            if (n > 16) idle();
            cycle();
            if (!bus_a.ready) chk("clear A.rv", bus_a.read_valid, 1'b0);
            if (bus_a.ready && ca == 0) ca = n;
            if (bus_b.ready && cb == 0) cb = n;
        end
        chk("clear A cycles", ca, 16);
        chk("clear B cycles", cb, 20);
        idle();

        for (int a = 0; a < 20; a++) begin
            re = 1'b1; ra = 5'(a);
            cycle();
            chk($sformatf("rdback%0d A.rv", a),   bus_a.read_valid, 1'b1);
            chk($sformatf("rdback%0d A.dout", a), bus_a.data_out, 16'hA5A5);
            chk($sformatf("rdback%0d A.err", a),  bus_a.range_error, (a >= 16) ? 1'b1 : 1'b0);
            chk($sformatf("rdback%0d B.dout", a), bus_b.data_out, 16'h0000);
            chk($sformatf("rdback%0d B.err", a),  bus_b.range_error, 1'b0);
        end

        for (int i = 0; i < 16; i++) begin
            re = vt[i].re; ra = vt[i].ra; we = vt[i].we; wa = vt[i].wa; wb = vt[i].wb; din = vt[i].din;
            cycle();
            chk($sformatf("vec%0d A.rv", i),   bus_a.read_valid,  vt[i].vld);
            chk($sformatf("vec%0d B.rv", i),   bus_b.read_valid,  vt[i].vld);
            chk($sformatf("vec%0d A.dout", i), bus_a.data_out,    vt[i].da);
            chk($sformatf("vec%0d B.dout", i), bus_b.data_out,    vt[i].db);
            chk($sformatf("vec%0d A.err", i),  bus_a.range_error, vt[i].ea);
            chk($sformatf("vec%0d B.err", i),  bus_b.range_error, vt[i].eb);
        end

        // Reset coinciding with an access: the access is discarded.
        rst = 1'b1; re = 1'b1; ra = 5'd6; we = 1'b1; wa = 5'd6; wb = 2'b11; din = 16'h1111;
        cycle();
        chk("rstacc A.rv",   bus_a.read_valid, 1'b0);
        chk("rstacc A.dout", bus_a.data_out, 16'h0000);
        chk("rstacc B.err",  bus_b.range_error, 1'b0);
        rst = 1'b0;
        idle();
        wait_ready("rstacc ready");
        re = 1'b1; ra = 5'd6;
        cycle();
        chk("rstacc A.rd6", bus_a.data_out, 16'hA5A5);
        chk("rstacc B.rd6", bus_b.data_out, 16'h0000);

        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(299, 0) == 0);
            re  = 1'($urandom_range(1, 0));
            we  = 1'($urandom_range(1, 0));
            ra  = 5'($urandom_range(31, 0));
            wa  = ($urandom_range(3, 0) == 0) ? ra : 5'($urandom_range(31, 0));
            wb  = 2'($urandom_range(3, 0));
            din = 16'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
